handshake_rr_arbiter: RTL and testbench
=======================================

Name: handshake_rr_arbiter

Overview:
- Shares one upstream req/ack producer channel (an `in`/`reg`/operator output node) among `num_req` downstream requesters.
- Arbitration is round-robin. This replaces broadcast fan-out where each datum must go to exactly one consumer, for example distributing a stream across replicated operator lanes.
- Uses the codebase's 4-phase-style pull handshake:
  - The requester holds `req` high.
  - The producer answers with a 1-cycle `ack` pulse, with data valid on that edge.
- Sits between the upstream operator's `req_r`/`ack_r`/`dout` and N consumers' `req_l`/`ack_l`/`din`.

Parameters:
- `data_width`, 32, width of the data word.
- `num_req`, 4, number of requester ports (2..16).
- `init_value`, 0, reset value of `dout`.

Ports:
- `clk`, input, 1, single clock, all state updates on its rising edge.
- `rst`, input, 1, reset: asynchronous, active-low (`rst`=0 resets immediately).
- `req_in`, input, `num_req`, level requests from consumers; bit i = requester i.
- `ack_out`, output, `num_req`, one-hot 1-cycle acknowledge to the granted requester.
- `dout`, output, `data_width`, delivered word. Shared by all requesters and valid while `ack_out` is nonzero.
- `up_req`, output, 1, request to the upstream producer.
- `up_ack`, input, 1, upstream 1-cycle acknowledge.
- `up_din`, input, `data_width`, upstream data, sampled when `up_ack`=1.
- `grant_id`, output, clog2(`num_req`), index of the current or last grant.
- `busy`, output, 1, high while a transaction is in flight (`state`≠IDLE).
- `xfer_count`, output, 32, total completed transfers.

Behaviour:
- Reset (`rst`=0, async) sets:
  - state=IDLE, `up_req`=0, `ack_out`=0, `dout`=`init_value`, `grant_id`=0, `xfer_count`=0.
  - last-grant pointer = `num_req`-1, so port 0 has first priority.
- FSM states: IDLE, FETCH, DELIVER.
- IDLE:
  - If `req_in`≠0, pick the first set bit searching from (pointer+1) mod `num_req` upward with wrap-around.
  - Register the pick into `grant_id`, set `up_req`=1, go to FETCH.
  - Otherwise stay in IDLE with outputs unchanged.
- FETCH:
  - Hold `up_req`=1 until `up_ack`=1 is sampled.
  - On that edge: `dout`←`up_din`, `up_req`←0, `ack_out`←one-hot(`grant_id`), go to DELIVER.
- DELIVER (exactly 1 cycle):
  - `ack_out`←0, pointer←`grant_id`, `xfer_count`←`xfer_count`+1 (wraps at 2^32), go to IDLE.
- Latency:
  - `req_in` seen at edge 0 → `up_req` high after edge 0.
  - Upstream ack at edge k → `ack_out` high during cycle k+1.
  - Minimum transfer period is 3 cycles.
- `dout` holds its value until the next capture.
- `up_req` is low in the cycle after `up_ack`, which satisfies producers that ignore `req` while their `ack` is high.
- Boundary conditions:
  - Requester drops `req_in` during FETCH: the transaction is committed. The word is still fetched and `ack_out` still pulses to that port; no data is lost or reissued.
  - `up_ack` in IDLE or DELIVER: ignored (no capture, no state change).
  - Simultaneous requests: exactly one grant per transaction. Every continuously requesting port is served within `num_req` transactions (starvation-free).
  - Only one request bit set: that port is served on every transaction regardless of the pointer.
  - Reset asserted mid-FETCH or mid-DELIVER: immediate return to reset values; a pending upstream ack is discarded.
- `ack_out` is never multi-hot, and is never high in two consecutive cycles.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=0, FETCH=1, DELIVER=2; 2 bits);
  - clog2 function for `grant_id` width.
- Sub-module `rr_priority_picker`, combinational:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, valid.
  - Implemented as a doubled-vector masked priority search.
- The FSM, capture register and counter stay in the top module.

Test Plan:
- Single requester, `num_req`=4: `req_in`=0001 held high, with a producer that acks 1 cycle after `up_req` and sends data 0,1,2 → `ack_out`=0001 three times, `dout`=0,1,2, period 3 cycles, `xfer_count`=3.
- All-request round-robin: `req_in`=1111 held high, data 10..17 → grants in order 0,1,2,3,0,1,2,3; port i receives 10+i and 14+i.
- Mid-FETCH withdrawal: port 2 granted, `req_in`[2] dropped before `up_ack`, upstream sends 0x55 → `ack_out`=0100 for 1 cycle with `dout`=0x55, then the next grant goes to port 3 if it is requesting.
- Spurious `up_ack` while IDLE with `req_in`=0 → `dout`, `ack_out`, `up_req` and `xfer_count` unchanged.
- Reset mid-transaction: drive `rst`=0 between clock edges during FETCH → `up_req`=0 and `busy`=0 without waiting for a clock edge. After release, `req_in`=1000 → port 3 granted (pointer was reset, search starts at 0).
- Randomized upstream delays of 0–5 cycles over 5000 transfers with `req_in`=1111 → each port's delivered words are a strictly increasing subsequence of the source data, and per-port grant counts differ by at most 1.

Source files
------------

// File: rtl/handshake_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// handshake_rr_arbiter_pkg
// Shared definitions for the round-robin handshake arbiter:
//   - state_t : FSM state encoding (IDLE=0, FETCH=1, DELIVER=2, 2 bits)
//   - clog2() : index width helper used for grant_id / pointer widths
// -----------------------------------------------------------------------------
package handshake_rr_arbiter_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DELIVER = 2'd2
   } state_t;

   // Width needed to index 'value' items. A single item still gets one bit,
   // so an index port is never zero-width.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 32'sd0;
      rem    = value - 32'sd1;
      while (rem > 32'sd0) begin
         result = result + 32'sd1;
         rem    = rem >>> 1;
      end
      if (result == 32'sd0) begin
         result = 32'sd1;
      end else begin
         result = result;
      end
      return result;
   endfunction

endpackage

// File: rtl/handshake_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// handshake_rr_arbiter_if
// Bundles the consumer-side and producer-side handshake signals of the arbiter.
//   req_in     : consumer level requests (bit i = requester i)
//   ack_out    : one-hot 1-cycle acknowledge to the granted consumer
//   dout       : delivered word, valid while ack_out is nonzero
//   up_req     : request to the upstream producer
//   up_ack     : upstream 1-cycle acknowledge
//   up_din     : upstream data, sampled when up_ack=1
//   grant_id   : index of the current or last grant
//   busy       : transaction in flight
//   xfer_count : total completed transfers
// Modports: slave = arbiter side, master = environment side.
// -----------------------------------------------------------------------------
interface handshake_rr_arbiter_if
   import handshake_rr_arbiter_pkg::*;
#(
   parameter int data_width = 32,
   parameter int num_req    = 4
);

   localparam int GID_W = clog2(num_req);

   logic [num_req-1:0]    req_in;
   logic [num_req-1:0]    ack_out;
   logic [data_width-1:0] dout;
   logic                  up_req;
   logic                  up_ack;
   logic [data_width-1:0] up_din;
   logic [GID_W-1:0]      grant_id;
   logic                  busy;
   logic [31:0]           xfer_count;

   modport slave (
      input  req_in, up_ack, up_din,
      output ack_out, dout, up_req, grant_id, busy, xfer_count
   );

   modport master (
      output req_in, up_ack, up_din,
      input  ack_out, dout, up_req, grant_id, busy, xfer_count
   );

endinterface

// File: rtl/handshake_rr_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin pick: first set request bit found searching from
// (i_ptr + 1) mod num_req upward with wrap-around.
//   i_req   : request vector
//   i_ptr   : index of the last grant
//   o_grant : one-hot grant
//   o_idx   : index of the granted bit
//   o_valid : some request was found
// -----------------------------------------------------------------------------
module rr_priority_picker
   import handshake_rr_arbiter_pkg::*;
#(
   parameter int num_req = 4,
   parameter int idx_w   = clog2(num_req)
) (
   input  logic [num_req-1:0] i_req,
   input  logic [idx_w-1:0]   i_ptr,
   output logic [num_req-1:0] o_grant,
   output logic [idx_w-1:0]   o_idx,
   output logic               o_valid
);

   logic [2*num_req-1:0] w_dbl_req;
   logic [2*num_req-1:0] w_masked;
   logic [2*num_req-1:0] w_hit;
   logic                 w_found;
   int                   w_start;

   // Doubling the vector turns the wrap-around into one linear scan: the low
   // copy is masked below the start point, the high copy covers the wrap.
   always_comb begin
      w_dbl_req = {i_req, i_req};
      w_masked  = '0;
      w_hit     = '0;
      w_found   = 1'b0;
      o_idx     = '0;
      if (int'(i_ptr) >= (num_req - 32'sd1)) begin
         w_start = 32'sd0;
      end else begin
         w_start = int'(i_ptr) + 32'sd1;
      end
      for (int i = 0; i < 2 * num_req; i++) begin
         if (i >= w_start) begin
            w_masked[i] = w_dbl_req[i];
         end else begin
            w_masked[i] = 1'b0;
         end
      end
      for (int i = 0; i < 2 * num_req; i++) begin
         if (!w_found && w_masked[i]) begin
            w_found  = 1'b1;
            w_hit[i] = 1'b1;
            if (i >= num_req) begin
               o_idx = idx_w'(i - num_req);
            end else begin
               o_idx = idx_w'(i);
            end
         end else begin
            w_found = w_found;
         end
      end
      o_grant = w_hit[num_req-1:0] | w_hit[2*num_req-1:num_req];
      o_valid = w_found;
   end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// -----------------------------------------------------------------------------
// handshake_rr_arbiter
// Shares one upstream req/ack producer among num_req pull-style consumers with
// round-robin arbitration. Each word goes to exactly one consumer.
//   clk  : clock, rising-edge state updates
//   rst  : asynchronous active-low reset
//   bus  : handshake_rr_arbiter_if.slave (consumer req/ack/dout, upstream
//          req/ack/din, grant_id, busy, xfer_count)
// Flow: IDLE picks a requester and raises up_req; FETCH waits for up_ack and
// captures up_din; DELIVER ends the 1-cycle ack_out pulse and advances the
// round-robin pointer.
// -----------------------------------------------------------------------------
module handshake_rr_arbiter
   import handshake_rr_arbiter_pkg::*;
#(
   parameter int                    data_width = 32,
   parameter int                    num_req    = 4,
   parameter logic [data_width-1:0] init_value = '0
) (
   input logic                   clk,
   input logic                   rst,
   handshake_rr_arbiter_if.slave bus
);

   localparam int               GID_W     = clog2(num_req);
   // Pointer starts at the last port so port 0 has first priority.
   localparam logic [GID_W-1:0] PTR_RESET = GID_W'(num_req - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [GID_W-1:0]      r_ptr;
   logic [GID_W-1:0]      r_grant_id;
   logic [num_req-1:0]    r_grant_oh;
   logic [num_req-1:0]    r_ack_out;
   logic [data_width-1:0] r_dout;
   logic                  r_up_req;
   logic                  r_busy;
   logic [31:0]           r_xfer_count;

   logic [GID_W-1:0]      w_ptr_nxt;
   logic [GID_W-1:0]      w_grant_id_nxt;
   logic [num_req-1:0]    w_grant_oh_nxt;
   logic [num_req-1:0]    w_ack_out_nxt;
   logic [data_width-1:0] w_dout_nxt;
   logic                  w_up_req_nxt;
   logic                  w_busy_nxt;
   logic [31:0]           w_xfer_nxt;

   logic [num_req-1:0]    w_pick_oh;
   logic [GID_W-1:0]      w_pick_idx;
   logic                  w_pick_valid;

   rr_priority_picker #(
      .num_req (num_req),
      .idx_w   (GID_W)
   ) u_picker (
      .i_req   (bus.req_in),
      .i_ptr   (r_ptr),
      .o_grant (w_pick_oh),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; up_ack outside FETCH has no effect.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_state_nxt = ST_FETCH;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (bus.up_ack) begin
               w_state_nxt = ST_DELIVER;
            end else begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_DELIVER: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM output logic: next values of every registered output.
   always_comb begin
      w_up_req_nxt   = r_up_req;
      w_ack_out_nxt  = r_ack_out;
      w_dout_nxt     = r_dout;
      w_grant_id_nxt = r_grant_id;
      w_grant_oh_nxt = r_grant_oh;
      w_ptr_nxt      = r_ptr;
      w_xfer_nxt     = r_xfer_count;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_grant_id_nxt = w_pick_idx;
               w_grant_oh_nxt = w_pick_oh;
               w_up_req_nxt   = 1'b1;
            end else begin
               w_up_req_nxt   = 1'b0;
            end
         end
         ST_FETCH: begin
            // The grant is committed here: a consumer dropping req_in no
            // longer cancels the fetch or the ack pulse.
            if (bus.up_ack) begin
               w_dout_nxt    = bus.up_din;
               w_up_req_nxt  = 1'b0;
               w_ack_out_nxt = r_grant_oh;
            end else begin
               w_up_req_nxt  = 1'b1;
            end
         end
         ST_DELIVER: begin
            w_ack_out_nxt = '0;
            w_ptr_nxt     = r_grant_id;
            w_xfer_nxt    = r_xfer_count + 32'd1;
         end
         default: begin
            w_up_req_nxt  = 1'b0;
            w_ack_out_nxt = '0;
         end
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // Output, capture and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_up_req     <= 1'b0;
         r_ack_out    <= '0;
         r_dout       <= init_value;
         r_grant_id   <= '0;
         r_grant_oh   <= '0;
         r_ptr        <= PTR_RESET;
         r_xfer_count <= 32'd0;
         r_busy       <= 1'b0;
      end else begin
         r_up_req     <= w_up_req_nxt;
         r_ack_out    <= w_ack_out_nxt;
         r_dout       <= w_dout_nxt;
         r_grant_id   <= w_grant_id_nxt;
         r_grant_oh   <= w_grant_oh_nxt;
         r_ptr        <= w_ptr_nxt;
         r_xfer_count <= w_xfer_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   assign bus.up_req     = r_up_req;
   assign bus.ack_out    = r_ack_out;
   assign bus.dout       = r_dout;
   assign bus.grant_id   = r_grant_id;
   assign bus.busy       = r_busy;
   assign bus.xfer_count = r_xfer_count;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_handshake_rr_arbiter
// Scoreboard bench: the upstream producer model pushes {expected port, word}
// when it acks; each ack_out pulse pops and compares. The expected port comes
// from an independent round-robin model.
// -----------------------------------------------------------------------------
module tb_handshake_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;

   handshake_rr_arbiter_if #(.data_width(DW), .num_req(N)) bus ();

   handshake_rr_arbiter #(
      .data_width (DW),
      .num_req    (N),
      .init_value (32'h0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          n_done = 0;
   int          model_ptr = N - 1;
   int          exp_port = 0;
   logic        prev_up_req = 1'b0;
   logic [N-1:0] prev_ack = '0;
   logic        in_fetch = 1'b0;
   int          prod_cnt = 0;
   int          prod_delay = 0;
   logic        rnd_delay = 1'b0;
   logic [31:0] data_base = 32'h0;
   int          prod_idx = 0;
   logic        spur = 1'b0;
   logic        chk_period = 1'b0;
   int          last_pulse_cyc = 0;
   logic [31:0] exp_dout = 32'h0;
   int          port_cnt[N];
   logic [31:0] last_data[N];
   logic        seen[N];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int rr_model(input int ptr, input logic [N-1:0] req);
      int idx;
      for (int k = 1; k <= N; k++) begin
         idx = (ptr + k) % N;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   // One clock: sample at negedge, score ack pulses, track picks, run producer.
   task automatic tick();
      exp_t         e;
      logic [N-1:0] oh;
      @(negedge clk);
      cyc++;
      if (!rst) begin
         sb_q.delete();
         in_fetch    = 1'b0;
         prev_up_req = 1'b0;
         prev_ack    = '0;
         model_ptr   = N - 1;
         bus.up_ack  = 1'b0;
         return;
      end
      if (bus.ack_out != '0) begin
         check_val("ack_gap", prev_ack, 0);
         if (sb_q.size() == 0) begin
            check_val("unexpected_ack", bus.ack_out, 0);
         end else begin
            e  = sb_q.pop_front();
            oh = '0;
            oh[e.port] = 1'b1;
            check_val("ack_port", bus.ack_out, oh);
            check_val("dout", bus.dout, e.data);
            check_val("grant_id", bus.grant_id, e.port);
            if (seen[e.port]) check_val("incr", bus.dout > last_data[e.port], 1);
            if (chk_period && n_done > 0) check_val("period", cyc - last_pulse_cyc, 3);
            seen[e.port]      = 1'b1;
            last_data[e.port] = bus.dout;
            port_cnt[e.port]++;
            last_pulse_cyc = cyc;
            exp_dout       = e.data;
            n_done++;
         end
      end
      prev_ack = bus.ack_out;
      // req_in has not been changed since the last posedge, so it is the
      // vector the arbiter picked from.
      if (bus.up_req && !prev_up_req) begin
         exp_port  = rr_model(model_ptr, bus.req_in);
         model_ptr = exp_port;
         in_fetch  = 1'b1;
         prod_cnt  = rnd_delay ? int'($urandom_range(5, 0)) : prod_delay;
      end
      prev_up_req = bus.up_req;
      if (bus.up_ack) begin
         bus.up_ack = 1'b0;
      end else if (spur) begin
         bus.up_ack = 1'b1;
         bus.up_din = 32'hDEAD_BEEF;
         spur       = 1'b0;
      end else if (in_fetch) begin
         if (prod_cnt == 0) begin
            bus.up_ack = 1'b1;
            bus.up_din = data_base + 32'(prod_idx);
            prod_idx++;
            e.port = exp_port;
            e.data = bus.up_din;
            sb_q.push_back(e);
            in_fetch = 1'b0;
         end else begin
            prod_cnt--;
         end
      end
   endtask

   task automatic prepare(input logic [31:0] base, input int delay, input logic rnd, input logic per);
      data_base  = base;
      prod_idx   = 0;
      prod_delay = delay;
      rnd_delay  = rnd;
      chk_period = per;
      n_done     = 0;
      for (int p = 0; p < N; p++) begin
         port_cnt[p] = 0;
         seen[p]     = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.req_in = '0;
      tick();
      tick();
      rst = 1'b1;
      exp_dout = 32'h0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int k;
      k = 0;
      while (n_done < target && k < budget) begin
         tick();
         k++;
      end
      check_val("done_count", n_done, target);
      bus.req_in = '0;
   endtask

   task automatic wait_up_req(input int budget);
      int k;
      k = 0;
      while (!bus.up_req && k < budget) begin
         tick();
         k++;
      end
      check_val("up_req_seen", bus.up_req, 1);
   endtask

   initial begin
      int mn;
      int mx;
      rst        = 1'b0;
      bus.req_in = '0;
      bus.up_ack = 1'b0;
      bus.up_din = '0;
      prepare(32'h0, 0, 1'b0, 1'b0);
      tick();
      tick();
      check_val("rst_up_req", bus.up_req, 0);
      check_val("rst_ack_out", bus.ack_out, 0);
      check_val("rst_dout", bus.dout, 0);
      check_val("rst_grant_id", bus.grant_id, 0);
      check_val("rst_xfer", bus.xfer_count, 0);
      check_val("rst_busy", bus.busy, 0);
      rst = 1'b1;

      // Single requester, producer acks one cycle after up_req.
      prepare(32'h0, 0, 1'b0, 1'b1);
      bus.req_in = 4'b0001;
      wait_done(3, 100);
      tick();
      tick();
      check_val("single_xfer", bus.xfer_count, 3);
      check_val("single_cnt0", port_cnt[0], 3);

      // Spurious up_ack while idle with no requests.
      spur = 1'b1;
      tick();
      tick();
      tick();
      check_val("spur_dout", bus.dout, exp_dout);
      check_val("spur_ack_out", bus.ack_out, 0);
      check_val("spur_up_req", bus.up_req, 0);
      check_val("spur_xfer", bus.xfer_count, 3);
      check_val("spur_busy", bus.busy, 0);

      // All ports requesting: grants 0,1,2,3,0,1,2,3 with data 10..17.
      do_reset();
      prepare(32'd10, 0, 1'b0, 1'b1);
      bus.req_in = 4'b1111;
      wait_done(8, 200);
      check_val("rr_port3_last", last_data[3], 17);
      check_val("rr_port0_last", last_data[0], 14);

      // Port 2 withdraws mid-FETCH; its word is still delivered, then port 3.
      do_reset();
      prepare(32'h55, 3, 1'b0, 1'b0);
      bus.req_in = 4'b1100;
      wait_up_req(20);
      bus.req_in = 4'b1000;
      wait_done(2, 100);
      check_val("wd_port2_data", last_data[2], 32'h55);
      check_val("wd_port3_data", last_data[3], 32'h56);

      // Asynchronous reset in the middle of FETCH.
      do_reset();
      prepare(32'h100, 4, 1'b0, 1'b0);
      bus.req_in = 4'b0001;
      wait_up_req(20);
      tick();
      check_val("pre_rst_busy", bus.busy, 1);
      #2;
      rst = 1'b0;
      #1;
      check_val("async_up_req", bus.up_req, 0);
      check_val("async_busy", bus.busy, 0);
      check_val("async_ack_out", bus.ack_out, 0);
      bus.req_in = '0;
      tick();
      tick();
      rst = 1'b1;
      prepare(32'h200, 0, 1'b0, 1'b0);
      bus.req_in = 4'b1000;
      wait_done(1, 50);
      tick();
      tick();
      check_val("post_rst_grant", bus.grant_id, 3);
      check_val("post_rst_xfer", bus.xfer_count, 1);
      check_val("post_rst_dout", bus.dout, 32'h200);

      // Random producer delays, all ports requesting.
      do_reset();
      prepare(32'h1000, 0, 1'b1, 1'b0);
      bus.req_in = 4'b1111;
      wait_done(5000, 60000);
      tick();
      tick();
      check_val("rnd_xfer", bus.xfer_count, 5000);
      mn = port_cnt[0];
      mx = port_cnt[0];
      for (int p = 1; p < N; p++) begin
         if (port_cnt[p] < mn) mn = port_cnt[p];
         if (port_cnt[p] > mx) mx = port_cnt[p];
      end
      check_val("rnd_fairness", (mx - mn) <= 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
